pc_seq: RTL and testbench

- Next-generation program counter for the core fetch stage, replacing the single absolute-jump counter.
- Adds signed relative branches, a parametrised hardware call/return stack, a sticky halt address and sticky error flags.
- `prog_ctr` feeds instruction memory directly.
- Control inputs come from the decoder/branch logic. `advance` is the per-instruction step strobe and is the successor of `nextFlag`.

---
 rtl/pc_pkg.sv | 45 ++++
 rtl/pc_ret_stack.sv | 59 +++++
 rtl/pc_seq.sv | 111 +++++++++++
 tb/tb_pc_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    // One PC update per advancing cycle; PC_HOLD means nothing changes.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_REL,
        PC_ABS,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Width of a counter that holds 0..depth inclusive.
    function automatic int pc_depth_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of an index into a depth-entry array.
    function automatic int pc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Priority when several enables are high: ret > call > abs > rel > increment.
    function automatic pc_op_e pc_decode(
        input logic advance,
        input logic halted,
        input logic ret_en,
        input logic call_en,
        input logic abs_en,
        input logic rel_en
    );
        pc_op_e op;
        op = PC_HOLD;
        if (advance && !halted) begin
            if (ret_en)       op = PC_RET;
            else if (call_en) op = PC_CALL;
            else if (abs_en)  op = PC_ABS;
            else if (rel_en)  op = PC_REL;
            else              op = PC_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO. Push-when-full and pop-when-empty are
// silently dropped here; the caller decides what they mean.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [D-1:0]                 wdata,
    output logic [D-1:0]                 rdata,
    output logic [pc_depth_w(DEPTH)-1:0] depth,
    output logic                         full,
    output logic                         empty
);

    localparam int SW = pc_depth_w(DEPTH);
    localparam int AW = pc_addr_w(DEPTH);

    logic [D-1:0]  mem [DEPTH];
    logic [SW-1:0] depth_m1;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign full     = (depth == SW'(DEPTH));
    assign empty    = (depth == '0);
    assign depth_m1 = depth - SW'(1);
    assign wr_idx   = depth[AW-1:0];
    assign top_idx  = depth_m1[AW-1:0];
    assign rdata    = mem[top_idx];

    // A pop takes precedence so a simultaneous request never corrupts the top.
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;

    // Entry count; the only stack state that needs a reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else if (do_pop) begin
            depth <= depth_m1;
        end else if (do_push) begin
            depth <= depth + SW'(1);
        end
    end

    // Entry storage; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter with relative branches, call/return stack,
// sticky halt and sticky stack error flags.
//
// Strobe semantics: advance is a one-cycle step request with no ready side.
// Each clk edge with advance=1 and halted=0 commits exactly one update chosen
// by the enables; with advance=0 every piece of state holds. prog_ctr shows
// the committed value in the cycle after the edge.
module pc_seq
    import pc_pkg::*;
#(
    parameter int           D         = 12,
    parameter int           OFFW      = 8,
    parameter int           DEPTH     = 4,
    parameter logic [D-1:0] HALT_ADDR = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    input  logic                         abs_en,
    input  logic                         rel_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [D-1:0]                 target,
    input  logic [OFFW-1:0]              offset,
    output logic [D-1:0]                 prog_ctr,
    output logic [pc_depth_w(DEPTH)-1:0] stack_depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         halted
);

    pc_op_e       op;
    logic [D-1:0] pc_plus1;
    logic [D-1:0] off_ext;
    logic [D-1:0] next_pc;
    logic [D-1:0] top_entry;
    logic         push;
    logic         pop;
    logic         set_ovf;
    logic         set_unf;

    assign op       = pc_decode(advance, halted, ret_en, call_en, abs_en, rel_en);
    assign pc_plus1 = prog_ctr + D'(1);
    assign off_ext  = D'($signed(offset));

    pc_ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_plus1),
        .rdata (top_entry),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Next-PC selection; failed calls/returns fall back to a plain increment.
    always_comb begin
        next_pc = prog_ctr;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            PC_INC:  next_pc = pc_plus1;
            PC_REL:  next_pc = prog_ctr + off_ext;
            PC_ABS:  next_pc = target;
            PC_CALL: begin
                if (stack_full) begin
                    next_pc = pc_plus1;
                    set_ovf = 1'b1;
                end else begin
                    next_pc = target;
                    push    = 1'b1;
                end
            end
            PC_RET: begin
                if (stack_empty) begin
                    next_pc = pc_plus1;
                    set_unf = 1'b1;
                end else begin
                    next_pc = top_entry;
                    pop     = 1'b1;
                end
            end
            default: next_pc = prog_ctr;
        endcase
    end

    // PC and sticky flags; only reset clears the flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
            halted   <= 1'b0;
        end else if (op != PC_HOLD) begin
            prog_ctr <= next_pc;
            if (set_ovf)                ovf_err <= 1'b1;
            if (set_unf)                unf_err <= 1'b1;
            if (next_pc == HALT_ADDR)   halted  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed vector table, hand-written reset
// sequences, and a randomized phase against a behavioural model.
module tb_pc_seq;

    localparam int D     = 12;
    localparam int OFFW  = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 3;
    localparam int W     = D + SW + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            advance, abs_en, rel_en, call_en, ret_en;
    logic [D-1:0]    target;
    logic [OFFW-1:0] offset;
    logic [D-1:0]    prog_ctr;
    logic [SW-1:0]   stack_depth;
    logic            stack_full, stack_empty, ovf_err, unf_err, halted;

    pc_seq #(
        .D         (D),
        .OFFW      (OFFW),
        .DEPTH     (DEPTH),
        .HALT_ADDR (12'hFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .abs_en      (abs_en),
        .rel_en      (rel_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .target      (target),
        .offset      (offset),
        .prog_ctr    (prog_ctr),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err),
        .halted      (halted)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] pack(input logic [D-1:0] pc, input int depth,
                                          input logic ovf, input logic unf, input logic halt);
        logic [SW-1:0] d;
        d = SW'(depth);
        return {pc, d, (depth == DEPTH), (depth == 0), ovf, unf, halt};
    endfunction

    task automatic check(input string name);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {prog_ctr, stack_depth, stack_full, stack_empty, ovf_err, unf_err, halted};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued, got %h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b halt=%b, expected pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b halt=%b",
                         name, got[W-1 -: D], got[4+SW:5], got[4], got[3], got[2], got[1], got[0],
                         exp[W-1 -: D], exp[4+SW:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         adv, ret, cal, jmp, rel;
        logic [D-1:0] tgt;
        logic [7:0]   off;
        logic [D-1:0] pc;
        int           depth;
        logic         ovf, unf, halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic adv, ret, cal, jmp, rel,
                                input logic [D-1:0] tgt, input logic [7:0] off,
                                input logic [D-1:0] pc, input int depth,
                                input logic ovf, unf, halt);
        vec_t t;
        t.adv = adv; t.ret = ret; t.cal = cal; t.jmp = jmp; t.rel = rel;
        t.tgt = tgt; t.off = off; t.pc = pc; t.depth = depth;
        t.ovf = ovf; t.unf = unf; t.halt = halt;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input vec_t v, input string name);
        advance = v.adv; ret_en = v.ret; call_en = v.cal; abs_en = v.jmp; rel_en = v.rel;
        target  = v.tgt; offset = v.off;
        exp_q.push_back(pack(v.pc, v.depth, v.ovf, v.unf, v.halt));
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic idle_inputs();
        advance = 1'b0; ret_en = 1'b0; call_en = 1'b0; abs_en = 1'b0; rel_en = 1'b0;
        target  = '0;   offset = '0;
    endtask

    // Called just after a sampled edge: reset lands mid-cycle, is checked
    // before any clock edge, is held across one busy edge, then released.
    task automatic do_async_reset(input string name);
        #2;
        reset   = 1'b0;
        advance = 1'b1; abs_en = 1'b1; target = 12'h0AA;
        exp_q.push_back(pack(12'h000, 0, 1'b0, 1'b0, 1'b0));
        #1;
        check(name);
        @(posedge clk);
        #1;
        exp_q.push_back(pack(12'h000, 0, 1'b0, 1'b0, 1'b0));
        check({name, "_hold"});
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [D-1:0] m_pc;
    logic [D-1:0] m_stk[$];
    logic         m_ovf, m_unf, m_halt;

    initial begin
        reset = 1'b0;
        idle_inputs();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack(12'h000, 0, 1'b0, 1'b0, 1'b0));
        check("reset_state");
        reset = 1'b1;

        //              adv ret cal jmp rel tgt      off    pc       dep ovf unf hlt
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 12'h000, 8'h00, D'(i), 0, 0, 0, 0));
        repeat (3)
            vecs.push_back(mk(0, 1, 1, 1, 1, 12'h123, 8'h10, 12'h005, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h010, 8'h00, 12'h010, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'h000, 8'hF0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'h000, 8'h7F, 12'h07F, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 12'h200, 8'h10, 12'h200, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'h000, 8'h80, 12'h180, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'h000, 8'hF0, 12'hFF0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'h000, 8'h20, 12'h010, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h100, 8'h00, 12'h100, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h300, 8'h00, 12'h300, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h400, 8'h00, 12'h400, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h500, 8'h00, 12'h500, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h600, 8'h00, 12'h600, 4, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h700, 8'h00, 12'h601, 4, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h501, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h401, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h301, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h101, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h020, 8'h00, 12'h020, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h021, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h054, 8'h00, 12'h054, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h022, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h054, 8'h00, 12'h054, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h080, 8'h00, 12'h080, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 12'h300, 8'h00, 12'h055, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 12'h300, 8'h00, 12'h056, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 12'h0F0, 8'h00, 12'h0F0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 12'h123, 8'h00, 12'h057, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'hFFE, 8'h00, 12'hFFE, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 12'h000, 8'h00, 12'hFFF, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 12'h010, 8'h00, 12'hFFF, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12'h010, 8'h00, 12'hFFF, 0, 1, 1, 1));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset out of the halted state
        do_async_reset("async_reset_halted");

        // backward relative wrap straight onto the halt address
        apply(mk(1, 0, 0, 0, 1, 12'h000, 8'hFF, 12'hFFF, 0, 0, 0, 1), "rel_wrap_halt");
        apply(mk(1, 1, 0, 0, 0, 12'h000, 8'h00, 12'hFFF, 0, 0, 0, 1), "halted_ignores_ret");
        do_async_reset("async_reset_rel");

        // randomized phase against a behavioural model
        m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
        for (int n = 0; n < 400; n++) begin
            logic [D-1:0] npc;
            logic [D-1:0] se;
            advance = ($urandom_range(0, 7) != 0);
            ret_en  = ($urandom_range(0, 3) == 0);
            call_en = ($urandom_range(0, 3) == 0);
            abs_en  = ($urandom_range(0, 3) == 0);
            rel_en  = ($urandom_range(0, 2) == 0);
            target  = D'($urandom_range(0, 12'hFFE));
            offset  = OFFW'($urandom_range(0, 255));
            se      = {{(D-OFFW){offset[OFFW-1]}}, offset};
            if (advance && !m_halt) begin
                if (ret_en) begin
                    if (m_stk.size() > 0) npc = m_stk.pop_back();
                    else begin npc = m_pc + 1'b1; m_unf = 1; end
                end else if (call_en) begin
                    if (m_stk.size() < DEPTH) begin m_stk.push_back(m_pc + 1'b1); npc = target; end
                    else begin npc = m_pc + 1'b1; m_ovf = 1; end
                end else if (abs_en) npc = target;
                else if (rel_en)     npc = m_pc + se;
                else                 npc = m_pc + 1'b1;
                m_pc = npc;
                if (npc == 12'hFFF) m_halt = 1;
            end
            exp_q.push_back(pack(m_pc, m_stk.size(), m_ovf, m_unf, m_halt));
            @(posedge clk);
            #1;
            check("random");
            if (m_halt || (n % 100 == 99)) begin
                do_async_reset("random_reset");
                m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
            end
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
